ram_access_arbiter: RTL and testbench

//  Shares the single-port data RAM between the CPU MEM stage and the program/data loader.

---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/arb_rr_pick.sv | 30 +++
 rtl/ram_access_arbiter.sv | 104 ++++++++++
 tb/tb_ram_access_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU MEM stage and the loader.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} arb_state_t;
    typedef enum logic {OWNER_CPU, OWNER_LDR} owner_t;

    localparam int ARB_LATENCY      = 3;
    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/arb_rr_pick.sv
// Grant selection between CPU and loader. Round-robin by default, fixed CPU priority
// when RAM_ARB_CPU_PRIORITY_EN is defined.
module arb_rr_pick
    import ram_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | ldr_req;
        grant_owner = OWNER_CPU;
`ifdef RAM_ARB_CPU_PRIORITY_EN
        if (!cpu_req && ldr_req) begin
            grant_owner = OWNER_LDR;
        end
`else
        // On a tie the requester that was not served last goes next.
        if (cpu_req && ldr_req) begin
            grant_owner = (last_grant == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
        end else if (ldr_req) begin
            grant_owner = OWNER_LDR;
        end
`endif
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the loader (req/ack handshakes).
// Tie policy lives in arb_rr_pick; define RAM_ARB_CPU_PRIORITY_EN for fixed CPU priority.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_wren,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_data
);

    arb_state_t state;
    arb_state_t next_state;
    owner_t     owner;
    owner_t     last_grant;
    logic       grant_valid;
    logic       grant_owner;

    arb_rr_pick u_pick (
        .cpu_req     (cpu_req),
        .ldr_req     (ldr_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = grant_valid ? GRANT : IDLE;
            GRANT:   next_state = WAIT;
            WAIT:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; once granted the access runs to completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= OWNER_CPU;
            last_grant     <= OWNER_LDR;
            ram_address    <= '0;
            ram_write_data <= '0;
            ram_wren       <= 1'b0;
            cpu_ack        <= 1'b0;
            ldr_ack        <= 1'b0;
            cpu_rdata      <= '0;
            ldr_rdata      <= '0;
        end else begin
            state   <= next_state;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= owner_t'(grant_owner);
                        if (grant_owner == OWNER_LDR) begin
                            ram_address    <= ldr_addr;
                            ram_write_data <= ldr_wdata;
                            ram_wren       <= ldr_wren;
                        end else begin
                            ram_address    <= cpu_addr;
                            ram_write_data <= cpu_wdata;
                            ram_wren       <= cpu_wren;
                        end
                    end
                end
                GRANT: ram_wren <= 1'b0;
                // RAM output is valid now; capture it and raise the ack shown during DONE.
                WAIT: begin
                    if (owner == OWNER_LDR) begin
                        ldr_rdata <= ram_data;
                        ldr_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= ram_data;
                        cpu_ack   <= 1'b1;
                    end
                end
                DONE: last_grant <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a registered-output RAM model.
// Tie expectations follow RAM_ARB_CPU_PRIORITY_EN when it is defined.
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    typedef struct {
        bit              is_ldr;
        bit              chk_data;
        logic [DATA_W-1:0] data;
        int              ack_at;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req, cpu_wren, ldr_req, ldr_wren;
    logic [ADDR_W-1:0] cpu_addr, ldr_addr;
    logic [DATA_W-1:0] cpu_wdata, ldr_wdata;
    logic              cpu_ack, ldr_ack, ram_wren;
    logic [DATA_W-1:0] cpu_rdata, ldr_rdata, ram_write_data, ram_data;
    logic [ADDR_W-1:0] ram_address;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    exp_t sb[$];
    exp_t cur;
    int   edge_cnt = 0;
    int   checks = 0;
    int   passed = 0;
    int   n;

    ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_wren       (cpu_wren),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .ldr_req        (ldr_req),
        .ldr_wren       (ldr_wren),
        .ldr_addr       (ldr_addr),
        .ldr_wdata      (ldr_wdata),
        .ldr_ack        (ldr_ack),
        .ldr_rdata      (ldr_rdata),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_wren       (ram_wren),
        .ram_data       (ram_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Single-port RAM with registered read output (old data on read-during-write).
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_write_data;
        ram_data <= mem[ram_address];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic pushExp(input bit is_ldr, input bit chk, input logic [DATA_W-1:0] data, input int ack_at);
        exp_t e;
        e.is_ldr = is_ldr; e.chk_data = chk; e.data = data; e.ack_at = ack_at;
        sb.push_back(e);
    endtask

    // Drives one requester through n_txn handshakes, re-requesting in the cycle after each ack.
    task automatic applyStimulus(input bit is_ldr, input logic wren, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input int n_txn);
        bit seen;
        for (int t = 0; t < n_txn; t++) begin
            if (t != 0) @(negedge clk);
            if (is_ldr) begin
                ldr_wren = wren; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
            end else begin
                cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
            end
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                seen = is_ldr ? ldr_ack : cpu_ack;
            end
            if (!seen) checkOutput(is_ldr ? "ldr_ack_timeout" : "cpu_ack_timeout", 0, 1);
            if (is_ldr) ldr_req = 1'b0;
            else        cpu_req = 1'b0;
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard in owner, cycle and data.
    always @(negedge clk) begin
        if (cpu_ack || ldr_ack) begin
            checkOutput("ack_overlap", {63'd0, cpu_ack & ldr_ack}, 64'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", {62'd0, ldr_ack, cpu_ack}, 64'd0);
            end else begin
                cur = sb.pop_front();
                checkOutput("ack_owner", {63'd0, ldr_ack}, {63'd0, cur.is_ldr});
                checkOutput("ack_cycle", 64'(edge_cnt), 64'(cur.ack_at));
                if (cur.chk_data)
                    checkOutput("rdata", 64'(cur.is_ldr ? ldr_rdata : cpu_rdata), 64'(cur.data));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ram_address"}, 64'(ram_address), 64'd0);
        checkOutput({tag, "_ram_write_data"}, 64'(ram_write_data), 64'd0);
        checkOutput({tag, "_ram_wren"}, 64'(ram_wren), 64'd0);
        checkOutput({tag, "_acks"}, {62'd0, ldr_ack, cpu_ack}, 64'd0);
        checkOutput({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
        checkOutput({tag, "_ldr_rdata"}, 64'(ldr_rdata), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_wren = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem['h10] = 32'hDEADBEEF;
        mem['h20] = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // CPU read: address registered in cycle 1, ack with data ARB_LATENCY edges after issue.
        n = edge_cnt;
        pushExp(0, 1, 32'hDEADBEEF, n + ARB_LATENCY);
        fork
            applyStimulus(0, 1'b0, 15'h10, '0, 1);
            begin
                @(negedge clk);
                checkOutput("t1_ram_address", 64'(ram_address), 64'h10);
                checkOutput("t1_ram_wren", 64'(ram_wren), 64'd0);
            end
        join
        repeat (2) @(negedge clk);

        // Loader write at the top address, then CPU reads it back.
        n = edge_cnt;
        pushExp(1, 0, '0, n + 3);
        fork
            applyStimulus(1, 1'b1, 15'h7FFF, 32'h12345678, 1);
            begin
                @(negedge clk);
                checkOutput("t2_ram_wren_c1", 64'(ram_wren), 64'd1);
                checkOutput("t2_ram_address", 64'(ram_address), 64'h7FFF);
                checkOutput("t2_ram_write_data", 64'(ram_write_data), 64'h12345678);
                @(negedge clk);
                checkOutput("t2_ram_wren_c2", 64'(ram_wren), 64'd0);
            end
        join
        repeat (2) @(negedge clk);
        n = edge_cnt;
        pushExp(0, 1, 32'h12345678, n + 3);
        applyStimulus(0, 1'b0, 15'h7FFF, '0, 1);
        repeat (2) @(negedge clk);

        // Tie right after reset, two transactions each.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n = edge_cnt;
`ifdef RAM_ARB_CPU_PRIORITY_EN
        pushExp(0, 1, 32'hDEADBEEF, n + 3);
        pushExp(0, 1, 32'hDEADBEEF, n + 7);
        pushExp(1, 1, 32'hCAFEF00D, n + 11);
        pushExp(1, 1, 32'hCAFEF00D, n + 15);
`else
        pushExp(0, 1, 32'hDEADBEEF, n + 3);
        pushExp(1, 1, 32'hCAFEF00D, n + 7);
        pushExp(0, 1, 32'hDEADBEEF, n + 11);
        pushExp(1, 1, 32'hCAFEF00D, n + 15);
`endif
        fork
            applyStimulus(0, 1'b0, 15'h10, '0, 2);
            applyStimulus(1, 1'b0, 15'h20, '0, 2);
        join
        repeat (2) @(negedge clk);

        // CPU keeps re-requesting for 5 transactions while one loader request is pending.
        n = edge_cnt;
`ifdef RAM_ARB_CPU_PRIORITY_EN
        for (int i = 0; i < 5; i++) pushExp(0, 1, 32'hDEADBEEF, n + 3 + 4 * i);
        pushExp(1, 1, 32'hCAFEF00D, n + 23);
`else
        pushExp(0, 1, 32'hDEADBEEF, n + 3);
        pushExp(1, 1, 32'hCAFEF00D, n + 7);
        for (int i = 0; i < 4; i++) pushExp(0, 1, 32'hDEADBEEF, n + 11 + 4 * i);
`endif
        fork
            applyStimulus(0, 1'b0, 15'h10, '0, 5);
            applyStimulus(1, 1'b0, 15'h20, '0, 1);
        join
        repeat (2) @(negedge clk);

        // Reset during WAIT of a CPU read: no ack, everything cleared, then a clean read.
        cpu_wren = 1'b0; cpu_addr = 15'h10; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checkAllZero("t5");
        reset_n = 1'b1;
        @(negedge clk);
        n = edge_cnt;
        pushExp(0, 1, 32'hCAFEF00D, n + 3);
        applyStimulus(0, 1'b0, 15'h20, '0, 1);
        repeat (2) @(negedge clk);

        // Request dropped during GRANT still completes exactly once.
        n = edge_cnt;
        pushExp(0, 1, 32'hDEADBEEF, n + 3);
        cpu_wren = 1'b0; cpu_addr = 15'h10; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t6_sb_drained", 64'(sb.size()), 64'd0);
        checkOutput("t6_cpu_rdata_held", 64'(cpu_rdata), 64'hDEADBEEF);

        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
